// File: rtl/nios2_debug_cmd_sysclk.sv
// System-clock side of the debug slave: strobe sync, IR/DR capture,
// take pulse decode and an FWFT command queue with sticky overflow.
module nios2_debug_cmd_sysclk #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACTION_BIT  = 34
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [SR_WIDTH-1:0]                sr,
    input  logic [IR_WIDTH-1:0]                ir_in,
    input  logic                               vs_udr,
    input  logic                               vs_uir,
    output logic [SR_WIDTH-1:0]                jdo,
    output logic [(1<<IR_WIDTH)-1:0]           take_action,
    output logic [(1<<IR_WIDTH)-1:0]           take_no_action,
    output logic                               cmd_valid,
    input  logic                               cmd_ready,
    output logic [IR_WIDTH-1:0]                cmd_ir,
    output logic [SR_WIDTH-1:0]                cmd_data,
    output logic [$clog2(FIFO_DEPTH):0]        cmd_count,
    output logic                               overflow,
    input  logic                               overflow_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(SYNC_STAGES + 2);
    localparam int EW = IR_WIDTH + SR_WIDTH;

    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_prev;
    logic                   uir_prev;
    logic [WW-1:0]          warm;
    logic                   armed;
    logic                   udr_evt;
    logic                   uir_evt;
    logic [IR_WIDTH-1:0]    ir_latched;

    logic [EW-1:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [EW-1:0]          head;
    logic                   full;
    logic                   pop;
    logic                   push;

    // Events stay masked until the sync chain has flushed after reset
    assign armed   = (warm == WW'(SYNC_STAGES + 1));
    assign udr_evt = udr_sync[SYNC_STAGES-1] & ~udr_prev & armed;
    assign uir_evt = uir_sync[SYNC_STAGES-1] & ~uir_prev & armed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync <= '0;
            uir_sync <= '0;
            udr_prev <= 1'b0;
            uir_prev <= 1'b0;
            warm     <= '0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_prev <= udr_sync[SYNC_STAGES-1];
            uir_prev <= uir_sync[SYNC_STAGES-1];
            if (!armed)
                warm <= warm + 1'b1;
        end
    end

    // A simultaneous uir event must not affect the udr decode of this edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_latched     <= '0;
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (udr_evt) begin
                jdo                        <= sr;
                take_action[ir_latched]    <= sr[ACTION_BIT];
                take_no_action[ir_latched] <= ~sr[ACTION_BIT];
            end
            if (uir_evt)
                ir_latched <= ir_in;
        end
    end

    assign cmd_valid = (cmd_count != '0);
    assign full      = (cmd_count == CW'(FIFO_DEPTH));
    assign pop       = cmd_valid & cmd_ready;
    assign push      = udr_evt & (~full | pop);
    assign head      = mem[rd_ptr];
    assign cmd_ir    = head[EW-1:SR_WIDTH];
    assign cmd_data  = head[SR_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {ir_latched, sr};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                cmd_count <= cmd_count + 1'b1;
            else if (pop && !push)
                cmd_count <= cmd_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else if (udr_evt && full && !pop)
            overflow <= 1'b1;
        else if (overflow_clr)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_nios2_debug_cmd_sysclk.sv
// Bench for nios2_debug_cmd_sysclk: directed table, corner
// sequences and random strobes against a queue-based model.
module tb_nios2_debug_cmd_sysclk;

    localparam int SRW = 38;
    localparam int IRW = 2;
    localparam int S   = 2;
    localparam int D   = 4;
    localparam int AB  = 34;
    localparam int NIR = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [SRW-1:0] sr = '0;
    logic [IRW-1:0] ir_in = '0;
    logic           vs_udr = 1'b0;
    logic           vs_uir = 1'b0;
    logic           cmd_ready = 1'b0;
    logic           overflow_clr = 1'b0;
    logic [SRW-1:0] jdo;
    logic [NIR-1:0] take_action;
    logic [NIR-1:0] take_no_action;
    logic           cmd_valid;
    logic [IRW-1:0] cmd_ir;
    logic [SRW-1:0] cmd_data;
    logic [2:0]     cmd_count;
    logic           overflow;

    nios2_debug_cmd_sysclk #(
        .SR_WIDTH(SRW), .IR_WIDTH(IRW), .SYNC_STAGES(S),
        .FIFO_DEPTH(D), .ACTION_BIT(AB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in),
        .vs_udr(vs_udr), .vs_uir(vs_uir), .jdo(jdo),
        .take_action(take_action), .take_no_action(take_no_action),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: edge-indexed strobe history and a command queue
    int                 n;
    bit                 hu[$];
    bit                 hi[$];
    logic [SRW-1:0]     m_jdo;
    logic [NIR-1:0]     m_ta;
    logic [NIR-1:0]     m_tna;
    logic [IRW-1:0]     m_ir;
    logic               m_ovf;
    logic [IRW+SRW-1:0] mq[$];

    function automatic bit hu_at(int e);
        return (e < 1) ? 1'b0 : hu[e-1];
    endfunction

    function automatic bit hi_at(int e);
        return (e < 1) ? 1'b0 : hi[e-1];
    endfunction

    function automatic void model_reset();
        n = 0;
        hu.delete();
        hi.delete();
        m_jdo = '0;
        m_ta = '0;
        m_tna = '0;
        m_ir = '0;
        m_ovf = 1'b0;
        mq.delete();
    endfunction

    function automatic void model_edge();
        bit ev_u, ev_i, pop, set_ovf;
        n++;
        hu.push_back(vs_udr);
        hi.push_back(vs_uir);
        ev_u = (n >= S + 2) && hu_at(n - S) && !hu_at(n - S - 1);
        ev_i = (n >= S + 2) && hi_at(n - S) && !hi_at(n - S - 1);
        m_ta = '0;
        m_tna = '0;
        set_ovf = 1'b0;
        if (ev_u) begin
            m_jdo = sr;
            if (sr[AB]) m_ta[m_ir] = 1'b1;
            else        m_tna[m_ir] = 1'b1;
        end
        pop = (mq.size() != 0) && cmd_ready;
        if (pop) void'(mq.pop_front());
        if (ev_u) begin
            if (mq.size() == D) set_ovf = 1'b1;
            else                mq.push_back({m_ir, sr});
        end
        if (ev_i) m_ir = ir_in;
        if (set_ovf)           m_ovf = 1'b1;
        else if (overflow_clr) m_ovf = 1'b0;
    endfunction

    task automatic cmp_model();
        logic [IRW+SRW-1:0] h;
        chk("m_take_action", take_action, m_ta);
        chk("m_take_no_action", take_no_action, m_tna);
        chk("m_jdo", jdo, m_jdo);
        chk("m_cmd_count", cmd_count, mq.size());
        chk("m_cmd_valid", cmd_valid, mq.size() != 0);
        chk("m_overflow", overflow, m_ovf);
        if (mq.size() != 0) begin
            h = mq[0];
            chk("m_cmd_ir", cmd_ir, h[IRW+SRW-1:SRW]);
            chk("m_cmd_data", cmd_data, h[SRW-1:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_edge();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic uir(input logic [IRW-1:0] v);
        ir_in = v;
        vs_uir = 1'b1;
        repeat (3) step();
        vs_uir = 1'b0;
        repeat (2) step();
    endtask

    task automatic udr(input logic [SRW-1:0] v,
                       output logic [NIR-1:0] ta,
                       output logic [NIR-1:0] tna);
        sr = v;
        vs_udr = 1'b1;
        step();
        step();
        chk("lat_early", {take_action, take_no_action}, 0);
        step();
        ta = take_action;
        tna = take_no_action;
        vs_udr = 1'b0;
        step();
        chk("pulse_1cyc", {take_action, take_no_action}, 0);
        step();
    endtask

    task automatic pop_one(input logic [SRW-1:0] exp_d);
        chk("drain_valid", cmd_valid, 1);
        chk("drain_data", cmd_data, exp_d);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
    endtask

    typedef struct {
        logic [IRW-1:0] ir;
        logic [SRW-1:0] sr;
        logic [NIR-1:0] ta;
        logic [NIR-1:0] tna;
    } vec_t;

    vec_t tv[5];

    initial begin
        logic [NIR-1:0] ta, tna, acc;
        int hcu, hci;

        tv[0] = '{2'd2, 38'h04_0000_1234, 4'b0100, 4'b0000};
        tv[1] = '{2'd2, 38'h00_0000_1234, 4'b0000, 4'b0100};
        tv[2] = '{2'd0, 38'h3F_FFFF_FFFF, 4'b0001, 4'b0000};
        tv[3] = '{2'd3, 38'h3B_FFFF_FFFF, 4'b0000, 4'b1000};
        tv[4] = '{2'd1, 38'h04_0000_0000, 4'b0010, 4'b0000};
        model_reset();

        // Strobe already high when reset releases
        vs_udr = 1'b1;
        repeat (2) step();
        chk("rst_count", cmd_count, 0);
        chk("rst_jdo", jdo, 0);
        reset_n = 1'b1;
        acc = '0;
        repeat (6) begin
            step();
            acc = acc | take_action | take_no_action;
        end
        chk("warm_no_event", acc, 0);
        chk("warm_no_push", cmd_count, 0);
        vs_udr = 1'b0;
        repeat (2) step();

        for (int i = 0; i < 5; i++) begin
            uir(tv[i].ir);
            udr(tv[i].sr, ta, tna);
            chk("tv_take_action", ta, tv[i].ta);
            chk("tv_take_no_action", tna, tv[i].tna);
            chk("tv_jdo", jdo, tv[i].sr);
            chk("tv_count1", cmd_count, 1);
            chk("tv_cmd_ir", cmd_ir, tv[i].ir);
            chk("tv_cmd_data", cmd_data, tv[i].sr);
            cmd_ready = 1'b1;
            step();
            cmd_ready = 1'b0;
            chk("tv_count0", cmd_count, 0);
        end

        // Overflow on the fifth command, then in-order drain
        for (int i = 1; i <= 5; i++) udr(SRW'(i), ta, tna);
        chk("ovf_count", cmd_count, 4);
        chk("ovf_set", overflow, 1);
        chk("ovf_jdo", jdo, 5);
        for (int i = 1; i <= 4; i++) pop_one(SRW'(i));
        chk("ovf_empty", cmd_valid, 0);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Push and pop on the same edge while full
        for (int i = 11; i <= 14; i++) udr(SRW'(i), ta, tna);
        chk("full_count", cmd_count, 4);
        sr = SRW'(15);
        vs_udr = 1'b1;
        step();
        step();
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk("pp_count", cmd_count, 4);
        chk("pp_ovf", overflow, 0);
        chk("pp_head", cmd_data, 12);
        vs_udr = 1'b0;
        repeat (2) step();
        for (int i = 12; i <= 15; i++) pop_one(SRW'(i));

        // uir and udr rising together: udr sees the old IR
        uir(2'd1);
        ir_in = 2'd3;
        sr = 38'h04_0000_00AA;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        repeat (3) step();
        chk("sim_take", take_action, 4'b0010);
        chk("sim_cmd_ir", cmd_ir, 1);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        repeat (2) step();
        udr(38'h04_0000_00BB, ta, tna);
        chk("sim_next_take", ta, 4'b1000);
        chk("sim_head_ir", cmd_ir, 1);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk("sim_next_ir", cmd_ir, 3);
        pop_one(38'h04_0000_00BB);

        // Reset in the middle of a queue
        udr(SRW'(21), ta, tna);
        udr(SRW'(22), ta, tna);
        chk("mid_count", cmd_count, 2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_count", cmd_count, 0);
        chk("mid_rst_valid", cmd_valid, 0);
        model_reset();
        step();
        reset_n = 1'b1;
        repeat (2) step();

        // Random strobes, handshake and clear
        hcu = 0;
        hci = 0;
        for (int c = 0; c < 2000; c++) begin
            if (hcu == 0) begin
                if (!vs_udr && $urandom_range(0, 1) == 1) begin
                    sr = SRW'({$urandom(), $urandom()});
                    vs_udr = 1'b1;
                end else begin
                    vs_udr = 1'b0;
                end
                hcu = $urandom_range(1, 5);
            end
            if (hci == 0) begin
                if (!vs_uir && $urandom_range(0, 3) == 0) begin
                    ir_in = IRW'($urandom_range(0, 3));
                    vs_uir = 1'b1;
                end else begin
                    vs_uir = 1'b0;
                end
                hci = $urandom_range(1, 5);
            end
            hcu--;
            hci--;
            cmd_ready = ($urandom_range(0, 2) == 0);
            overflow_clr = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
